// File: rtl/top_leds_blink_pkg.sv
// rtl/top_leds_blink_pkg.sv - shared constants for the LED output port
package top_leds_blink_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_PERIOD_WIDTH = 16;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_OUT      = 3'd1;
    localparam logic [2:0] ADDR_MASK     = 3'd2;
    localparam logic [2:0] ADDR_PERIOD   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

endpackage

// File: rtl/top_leds_blink_blink_prescaler.sv
// rtl/top_leds_blink_blink_prescaler.sv - reloadable down-counter producing the blink phase
module blink_prescaler
    import top_leds_blink_pkg::*;
#(
    parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    load,
    output logic                    phase
);

    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    phase_q, phase_d;

    // A load overrides a toggle due on the same cycle; period==0 parks the phase high.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load) begin
            cnt_d   = period;
            phase_d = 1'b1;
        end else if (period == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = period;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - PERIOD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/top_leds_blink.sv
// rtl/top_leds_blink.sv - Avalon-MM LED output port with set/clear and masked blink
module top_leds_blink
    import top_leds_blink_pkg::*;
#(
    parameter int                  DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int                  PERIOD_WIDTH = DEF_PERIOD_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic                    wr;
    logic [DATA_WIDTH-1:0]   wd_data;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   mask_q, mask_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    period_load;
    logic                    phase;
    logic [DATA_WIDTH-1:0]   out_q, out_d;
    logic [31:0]             rd_q, rd_d;
    logic                    unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd_data   = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata[31:PERIOD_WIDTH];

    always_comb begin
        data_d      = data_q;
        mask_d      = mask_q;
        period_d    = period_q;
        period_load = 1'b0;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_d = wd_data;
                ADDR_MASK:     mask_d = wd_data;
                ADDR_PERIOD: begin
                    period_d    = writedata[PERIOD_WIDTH-1:0];
                    period_load = 1'b1;
                end
                ADDR_OUTSET:   data_d = data_q | wd_data;
                ADDR_OUTCLEAR: data_d = data_q & ~wd_data;
                default:       ;
            endcase
        end
    end

    // The prescaler sees the incoming period on a load so the counter restarts from the new value.
    blink_prescaler #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_d),
        .load    (period_load),
        .phase   (phase)
    );

    always_comb begin
        out_d = data_q & ~(mask_q & {DATA_WIDTH{~phase}});
    end

    always_comb begin
        rd_d = '0;
        case (address)
            ADDR_DATA:   rd_d[DATA_WIDTH-1:0]   = data_q;
            ADDR_OUT:    rd_d[DATA_WIDTH-1:0]   = out_q;
            ADDR_MASK:   rd_d[DATA_WIDTH-1:0]   = mask_q;
            ADDR_PERIOD: rd_d[PERIOD_WIDTH-1:0] = period_q;
            default:     rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE;
            mask_q   <= '0;
            period_q <= '0;
            out_q    <= '0;
            rd_q     <= '0;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            out_q    <= out_d;
            rd_q     <= rd_d;
        end
    end

    assign out_port = out_q;
    assign readdata = rd_q;

endmodule

// File: tb/tb_top_leds_blink.sv
// tb/tb_top_leds_blink.sv - table-driven and sequence checks for top_leds_blink
module tb_top_leds_blink;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_cmp;
    int n_bad;

    top_leds_blink #(
        .DATA_WIDTH   (8),
        .PERIOD_WIDTH (16),
        .RESET_VALUE  (8'h3C)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic c, input logic w, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = c;
        write_n    = w;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic c, input logic w, input logic [2:0] a,
                                input logic [31:0] d, input logic [7:0] eo, input logic [31:0] er);
        vec_t v;
        v.cs = c; v.wn = w; v.addr = a; v.wd = d; v.exp_out = eo; v.exp_rd = er;
        return v;
    endfunction

    function automatic logic [7:0] blink_out(input int j);
        return (((j / 4) % 2) == 0) ? 8'hFF : 8'hF0;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Each row is one clock; expectations are sampled just after that edge.
        vecs[0]  = mk(1, 1, 3'd0, 32'h0000_0000, 8'h3C, 32'h3C);
        vecs[1]  = mk(1, 0, 3'd0, 32'h0000_00A5, 8'h3C, 32'h3C);
        vecs[2]  = mk(1, 1, 3'd0, 32'h0000_0000, 8'hA5, 32'hA5);
        vecs[3]  = mk(1, 0, 3'd4, 32'h0000_000A, 8'hA5, 32'h00);
        vecs[4]  = mk(1, 0, 3'd5, 32'h0000_0081, 8'hAF, 32'h00);
        vecs[5]  = mk(1, 1, 3'd0, 32'h0000_0000, 8'h2E, 32'h2E);
        vecs[6]  = mk(1, 1, 3'd1, 32'h0000_0000, 8'h2E, 32'h2E);
        vecs[7]  = mk(1, 0, 3'd1, 32'h0000_00FF, 8'h2E, 32'h2E);
        vecs[8]  = mk(1, 0, 3'd6, 32'h0000_00FF, 8'h2E, 32'h00);
        vecs[9]  = mk(1, 0, 3'd7, 32'h0000_00FF, 8'h2E, 32'h00);
        vecs[10] = mk(0, 0, 3'd0, 32'h0000_0000, 8'h2E, 32'h2E);
        vecs[11] = mk(1, 1, 3'd0, 32'h0000_0000, 8'h2E, 32'h2E);
        vecs[12] = mk(0, 0, 3'd2, 32'h0000_00FF, 8'h2E, 32'h00);
        vecs[13] = mk(1, 1, 3'd2, 32'h0000_0000, 8'h2E, 32'h00);
        vecs[14] = mk(1, 1, 3'd3, 32'h0000_0000, 8'h2E, 32'h00);
        vecs[15] = mk(1, 0, 3'd2, 32'hFFFF_FF0F, 8'h2E, 32'h00);
        vecs[16] = mk(1, 1, 3'd2, 32'h0000_0000, 8'h2E, 32'h0F);

        reset_n    = 1'b0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {24'h0, out_port}, 32'h00);
        chk("reset_rd", readdata, 32'h0);

        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        reset_n    = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd);
            chk($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
            chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
        end

        // Blink: data FF, mask 0F, period 3 (upper writedata bits ignored).
        cyc(1, 0, 3'd0, 32'h0000_00FF);
        cyc(1, 0, 3'd3, 32'hABCD_0003);
        for (int k = 1; k <= 12; k++) begin
            if (k < 12) cyc(1, 1, 3'd1, 32'h0);
            else        cyc(1, 0, 3'd3, 32'h0000_0005);
            chk($sformatf("blink%0d_out", k), {24'h0, out_port}, {24'h0, blink_out(k - 1)});
            if (k < 12)
                chk($sformatf("blink%0d_rd", k), readdata,
                    {24'h0, (k == 1) ? 8'hFF : blink_out(k - 2)});
            else
                chk("blink_rd_period", readdata, 32'h3);
        end

        // Period write landed on a due toggle: phase stays high for six more cycles.
        for (int j = 1; j <= 7; j++) begin
            cyc(1, 1, 3'd3, 32'h0);
            chk($sformatf("coll%0d_out", j), {24'h0, out_port}, (j <= 6) ? 32'hFF : 32'hF0);
            chk($sformatf("coll%0d_rd", j), readdata, 32'h5);
        end

        // Disable while phase is low.
        cyc(1, 0, 3'd3, 32'h0);
        chk("dis_out_edge", {24'h0, out_port}, 32'hF0);
        for (int j = 0; j < 10; j++) begin
            cyc(1, 1, 3'd3, 32'h0);
            chk($sformatf("dis%0d_out", j), {24'h0, out_port}, 32'hFF);
        end
        chk("dis_rd_period", readdata, 32'h0);

        // Asynchronous reset in the middle of a low phase.
        cyc(1, 0, 3'd3, 32'h0000_0003);
        repeat (6) cyc(1, 1, 3'd1, 32'h0);
        chk("pre_rst_out", {24'h0, out_port}, 32'hF0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out", {24'h0, out_port}, 32'h00);
        chk("async_rst_rd", readdata, 32'h0);
        @(negedge clk);
        address    = 3'd2;
        chipselect = 1'b1;
        write_n    = 1'b1;
        reset_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out", {24'h0, out_port}, 32'h3C);
        chk("post_rst_mask", readdata, 32'h0);
        cyc(1, 1, 3'd3, 32'h0);
        chk("post_rst_period", readdata, 32'h0);
        for (int j = 0; j < 8; j++) begin
            cyc(1, 1, 3'd0, 32'h0);
            chk($sformatf("post_rst%0d_out", j), {24'h0, out_port}, 32'h3C);
        end
        chk("post_rst_data", readdata, 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
